// File: rtl/boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to IM/DM.
// Optional macro BOOT_CHECKSUM_EN adds a running word sum compared against load_csum on completion.
module boot_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic [13:0] load_base,
   input  logic [14:0] load_len,
   input  logic [1:0]  load_dest,
   input  logic [31:0] load_csum,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_byte,
   output logic        mem_im_we,
   output logic        mem_dm_we,
   output logic [13:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [14:0] words_written
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t      state, state_next;
   logic [13:0] base_q;
   logic [14:0] len_q;
   logic [1:0]  dest_q;
   logic [1:0]  byte_cnt;
   logic [31:0] word_q;
   logic [14:0] count_q;
   logic        err_q;
   logic        accept;
   logic        xfer;
   logic        last_word;

   assign accept    = load_start && ((state == IDLE) || (state == DONE));
   assign xfer      = in_valid && in_ready;
   assign last_word = ((count_q + 15'd1) == len_q);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (load_start) state_next = (load_len == 15'd0) ? DONE : LOAD;
         LOAD:       if (xfer && (byte_cnt == 2'd3)) state_next = WRITE;
         WRITE:      state_next = last_word ? DONE : LOAD;
         default:    state_next = IDLE;
      endcase
   end

   // Captured parameters, byte assembly and the word counter; a load_start
   // outside IDLE/DONE never reaches these registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q   <= '0;
         len_q    <= '0;
         dest_q   <= '0;
         byte_cnt <= '0;
         word_q   <= '0;
         count_q  <= '0;
      end else begin
         if (accept) begin
            base_q   <= load_base;
            len_q    <= load_len;
            dest_q   <= load_dest;
            byte_cnt <= '0;
            count_q  <= '0;
         end
         if (xfer) begin
            word_q[{byte_cnt, 3'b000} +: 8] <= in_byte;
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == WRITE) count_q <= count_q + 15'd1;
      end
   end

`ifdef BOOT_CHECKSUM_EN
   logic [31:0] sum_q;
   logic [31:0] csum_q;

   // err is resolved on entry to DONE; a zero-length load compares against an empty sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         csum_q <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         sum_q  <= '0;
         csum_q <= load_csum;
         err_q  <= (load_len == 15'd0) && (load_csum != 32'd0);
      end else if (state == WRITE) begin
         sum_q <= sum_q + word_q;
         if (last_word) err_q <= ((sum_q + word_q) != csum_q);
      end
   end
`else
   logic unused_csum;
   assign unused_csum = ^load_csum;
   assign err_q       = 1'b0;
`endif

   assign in_ready      = (state == LOAD);
   assign mem_im_we     = (state == WRITE) && dest_q[0];
   assign mem_dm_we     = (state == WRITE) && dest_q[1];
   assign mem_addr      = base_q + count_q[13:0];
   assign mem_wdata     = word_q;
   assign busy          = (state == LOAD) || (state == WRITE);
   assign done          = (state == DONE);
   assign err           = err_q;
   assign cpu_rst       = !((state == DONE) && !err_q);
   assign words_written = count_q;

endmodule
